// File: rtl/ecg_window_loader_if.sv
// Stream bundle for ecg_window_loader: raw sample input and packed window output.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both 1. A source holds valid and its data steady until that edge.
// Ready may be driven independently of valid. Here s_valid/s_ready carry
// samples in and x_valid/x_ready carry the assembled window out.
//
// The "slave" modport is the loader side. The "master" modport is the
// producer/consumer side.
interface ecg_window_loader_if #(
    parameter int BITSIZE = 16,
    parameter int NELEM   = 10
);
    logic [BITSIZE-1:0]       s_data;
    logic                     s_valid;
    logic                     s_ready;
    logic [BITSIZE*NELEM-1:0] x;
    logic                     x_valid;
    logic                     x_ready;

    modport master (
        output s_data, s_valid, x_ready,
        input  s_ready, x, x_valid
    );

    modport slave (
        input  s_data, s_valid, x_ready,
        output s_ready, x, x_valid
    );
endinterface

// File: rtl/ecg_window_loader.sv
// ecg_window_loader: converts two's-complement ECG samples to sign-magnitude
// and packs NELEM of them into the classifier input vector x. Element 0 is
// the oldest sample.
//
// Optional feature: define ECG_WINDOW_LOADER_OVERLAP_EN for a sliding window.
// In that mode the next window needs only STRIDE new samples. Without the
// macro, windows are disjoint blocks of NELEM samples.
module ecg_window_loader #(
    parameter int BITSIZE = 16,
    parameter int NELEM   = 10,
    parameter int SHIFT   = 0,
    parameter int STRIDE  = 5
) (
    input  logic                clk,
    input  logic                reset,      // asynchronous, active low
    ecg_window_loader_if.slave  bus,
    output logic                sat_seen,
    output logic [15:0]         win_cnt,
    output logic                dbg_state   // 0 = FILL, 1 = FULL
);
    localparam int CNT_W = $clog2(NELEM + 1);
    localparam int MAG_W = BITSIZE - 1;
    localparam int XW    = BITSIZE * NELEM;

    // Fill count that remains after the consumer accepts a window.
`ifdef ECG_WINDOW_LOADER_OVERLAP_EN
    localparam logic [CNT_W-1:0] REFILL_CNT = CNT_W'(NELEM - STRIDE);
`else
    localparam logic [CNT_W-1:0] REFILL_CNT = '0;
`endif

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [XW-1:0]      x_q, x_d;
    logic               s_ready_q, s_ready_d;
    logic               x_valid_q, x_valid_d;
    logic               sat_q, sat_d;
    logic [15:0]        win_cnt_q, win_cnt_d;

    logic [BITSIZE-1:0] neg_data;
    logic [MAG_W-1:0]   mag_raw;
    logic [MAG_W-1:0]   mag_shift;
    logic               conv_sign;
    logic               conv_sat;
    logic [BITSIZE-1:0] conv_word;
    logic               capture;

    // Two's complement to sign-magnitude conversion. The most negative code
    // saturates. A magnitude that shifts down to zero never carries a sign.
    always_comb begin
        neg_data = -bus.s_data;
        conv_sat = 1'b0;
        if (!bus.s_data[BITSIZE-1]) begin
            mag_raw = bus.s_data[MAG_W-1:0];
        end else if (bus.s_data[MAG_W-1:0] == '0) begin
            mag_raw  = '1;
            conv_sat = 1'b1;
        end else begin
            mag_raw = neg_data[MAG_W-1:0];
        end
        mag_shift = mag_raw >> SHIFT;
        conv_sign = bus.s_data[BITSIZE-1] && (mag_shift != '0);
        conv_word = {conv_sign, mag_shift};
    end

    // Next-state logic. FILL takes samples into the shift register. FULL
    // holds x stable until the consumer accepts it. s_ready and x_valid are
    // registered, so the two states never overlap: no capture happens while
    // a window is being offered.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        x_d       = x_q;
        s_ready_d = s_ready_q;
        x_valid_d = x_valid_q;
        sat_d     = sat_q;
        win_cnt_d = win_cnt_q;
        capture   = bus.s_valid && s_ready_q;
        case (state_q)
            ST_FILL: begin
                s_ready_d = 1'b1;
                x_valid_d = 1'b0;
                if (capture) begin
                    x_d   = {conv_word, x_q[XW-1:BITSIZE]};
                    cnt_d = cnt_q + CNT_W'(1);
                    sat_d = sat_q | conv_sat;
                    if (cnt_q == CNT_W'(NELEM - 1)) begin
                        state_d   = ST_FULL;
                        s_ready_d = 1'b0;
                        x_valid_d = 1'b1;
                    end
                end
            end
            ST_FULL: begin
                s_ready_d = 1'b0;
                x_valid_d = 1'b1;
                if (bus.x_ready) begin
                    state_d   = ST_FILL;
                    s_ready_d = 1'b1;
                    x_valid_d = 1'b0;
                    cnt_d     = REFILL_CNT;
                    win_cnt_d = win_cnt_q + 16'd1;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    // State and output registers. s_ready stays low while reset is asserted
    // and rises one cycle after reset is released.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_FILL;
            cnt_q     <= '0;
            x_q       <= '0;
            s_ready_q <= 1'b0;
            x_valid_q <= 1'b0;
            sat_q     <= 1'b0;
            win_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            x_q       <= x_d;
            s_ready_q <= s_ready_d;
            x_valid_q <= x_valid_d;
            sat_q     <= sat_d;
            win_cnt_q <= win_cnt_d;
        end
    end

    assign bus.s_ready = s_ready_q;
    assign bus.x_valid = x_valid_q;
    assign bus.x       = x_q;
    assign sat_seen    = sat_q;
    assign win_cnt     = win_cnt_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_ecg_window_loader.sv
// Testbench for ecg_window_loader. It drives two instances in lockstep,
// one with SHIFT=0 and one with SHIFT=2. The reference model tracks the
// stream of accepted samples and windows by counts and queues.
module tb_ecg_window_loader;
    localparam int BW = 16;
    localparam int NE = 10;
    localparam int XW = BW * NE;
`ifdef ECG_WINDOW_LOADER_OVERLAP_EN
    localparam int STEP = 5;
`else
    localparam int STEP = NE;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          drv_valid;
    logic [BW-1:0] drv_data;
    logic          drv_xr;

    ecg_window_loader_if #(.BITSIZE(BW), .NELEM(NE)) bus0 ();
    ecg_window_loader_if #(.BITSIZE(BW), .NELEM(NE)) bus2 ();

    assign bus0.s_data  = drv_data;
    assign bus0.s_valid = drv_valid;
    assign bus0.x_ready = drv_xr;
    assign bus2.s_data  = drv_data;
    assign bus2.s_valid = drv_valid;
    assign bus2.x_ready = drv_xr;

    logic        sat0, sat2, st0, st2;
    logic [15:0] wc0, wc2;

    ecg_window_loader #(.BITSIZE(BW), .NELEM(NE), .SHIFT(0), .STRIDE(5)) dut0 (
        .clk(clk), .reset(rst_n), .bus(bus0),
        .sat_seen(sat0), .win_cnt(wc0), .dbg_state(st0)
    );
    ecg_window_loader #(.BITSIZE(BW), .NELEM(NE), .SHIFT(2), .STRIDE(5)) dut2 (
        .clk(clk), .reset(rst_n), .bus(bus2),
        .sat_seen(sat2), .win_cnt(wc2), .dbg_state(st2)
    );

    // ---------------- reference model ----------------
    int          n_acc;       // samples accepted since reset
    int          n_win;       // windows accepted since reset
    int          edges;       // clock edges since reset release
    logic [BW-1:0] exp_q[$];  // last NE converted samples, SHIFT=0
    logic [BW-1:0] exp2_q[$]; // same, SHIFT=2
    logic        exp_sat;
    logic [15:0] exp_wc;

    int errors = 0;
    int checks = 0;

    function automatic logic [BW-1:0] conv_ref(input logic [BW-1:0] d, input int sh);
        int v;
        int mag;
        logic [BW-1:0] r;
        v = int'($signed(d));
        if (v == -32768) mag = 32767;
        else if (v < 0)  mag = -v;
        else             mag = v;
        mag = mag >> sh;
        r[15]   = (v < 0) && (mag != 0);
        r[14:0] = mag[14:0];
        return r;
    endfunction

    function automatic logic [XW-1:0] pack_last(input logic [BW-1:0] q[$]);
        logic [XW-1:0] r;
        int idx;
        r = '0;
        for (int i = 0; i < NE; i++) begin
            idx = q.size() - NE + i;
            if (idx >= 0) r[BW*i +: BW] = q[idx];
        end
        return r;
    endfunction

    function automatic logic exp_xv();
        return n_acc >= NE + n_win * STEP;
    endfunction

    function automatic logic exp_sr();
        return !exp_xv() && (edges >= 1);
    endfunction

    task automatic model_reset();
        n_acc   = 0;
        n_win   = 0;
        edges   = 0;
        exp_q.delete();
        exp2_q.delete();
        exp_sat = 1'b0;
        exp_wc  = '0;
    endtask

    task automatic model_update(input logic sv, input logic [BW-1:0] d, input logic xr);
        logic cap;
        logic acc;
        cap = sv && exp_sr();
        acc = xr && exp_xv();
        if (cap) begin
            exp_q.push_back(conv_ref(d, 0));
            exp2_q.push_back(conv_ref(d, 2));
            if (exp_q.size() > NE) void'(exp_q.pop_front());
            if (exp2_q.size() > NE) void'(exp2_q.pop_front());
            n_acc++;
            if (d == 16'h8000) exp_sat = 1'b1;
        end
        if (acc) begin
            n_win++;
            exp_wc = exp_wc + 16'd1;
        end
        edges++;
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [XW-1:0] act, input logic [XW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("s_ready",  XW'(bus0.s_ready), XW'(exp_sr()));
        chk("x_valid",  XW'(bus0.x_valid), XW'(exp_xv()));
        chk("x",        bus0.x,            pack_last(exp_q));
        chk("sat_seen", XW'(sat0),         XW'(exp_sat));
        chk("win_cnt",  XW'(wc0),          XW'(exp_wc));
        chk("s2_x_valid", XW'(bus2.x_valid), XW'(exp_xv()));
        chk("s2_x",     bus2.x,            pack_last(exp2_q));
        chk("s2_win_cnt", XW'(wc2),        XW'(exp_wc));
    endtask

    // ---------------- drivers ----------------
    // One clock: drive at the negedge, let the posedge act, check at the next negedge.
    task automatic cycle(input logic sv, input logic [BW-1:0] d, input logic xr);
        drv_valid = sv;
        drv_data  = d;
        drv_xr    = xr;
        model_update(sv, d, xr);
        @(negedge clk);
        check_all();
    endtask

    // Offer one sample and hold it until it is taken, within a cycle budget.
    task automatic send(input logic [BW-1:0] d, input logic xr);
        int   t;
        logic taken;
        t = 0;
        taken = 1'b0;
        while (!taken && t < 100) begin
            taken = exp_sr();
            cycle(1'b1, d, xr);
            t++;
        end
        if (!taken) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no capture expected capture within 100 cycles");
        end
        drv_valid = 1'b0;
    endtask

    // Assert reset dly time units after the current negedge (asynchronous when dly>0).
    task automatic do_reset(input int dly);
        drv_valid = 1'b0;
        drv_xr    = 1'b0;
        if (dly > 0) #(dly);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_x",       bus0.x,               '0);
        chk("rst_x_valid", XW'(bus0.x_valid),    '0);
        chk("rst_s_ready", XW'(bus0.s_ready),    '0);
        chk("rst_sat",     XW'(sat0),            '0);
        chk("rst_win_cnt", XW'(wc0),             '0);
        chk("rst_s2_x",    bus2.x,               '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [BW-1:0] din;
        logic [BW-1:0] e0;   // expected element, SHIFT=0
        logic [BW-1:0] e2;   // expected element, SHIFT=2
    } conv_vec_t;

    conv_vec_t tab[NE];

    function automatic logic [BW-1:0] rand_data();
        int k;
        k = $urandom_range(0, 7);
        if (k == 0) return 16'h8000;
        if (k == 1) return 16'h0000;
        if (k == 2) return 16'($urandom_range(0, 7)) - 16'd3;
        return 16'($urandom);
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        logic          pv;
        logic [BW-1:0] pd;
        logic          xr;
        logic          acc;

        tab[0] = '{16'h0001, 16'h0001, 16'h0000};
        tab[1] = '{16'hFFFD, 16'h8003, 16'h0000};
        tab[2] = '{16'h8000, 16'hFFFF, 16'h9FFF};
        tab[3] = '{16'h0000, 16'h0000, 16'h0000};
        tab[4] = '{16'h7FFF, 16'h7FFF, 16'h1FFF};
        tab[5] = '{16'hFFFF, 16'h8001, 16'h0000};
        tab[6] = '{16'h0010, 16'h0010, 16'h0004};
        tab[7] = '{16'h8001, 16'hFFFF, 16'h9FFF};
        tab[8] = '{16'h1234, 16'h1234, 16'h048D};
        tab[9] = '{16'hEDCC, 16'h9234, 16'h848D};

        rst_n     = 1'b0;
        drv_valid = 1'b0;
        drv_data  = '0;
        drv_xr    = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset(0);

        // Basic fill: 1..10 back to back.
        for (int i = 1; i <= NE; i++) send(16'(i), 1'b1);
        chk("basic_x_valid", XW'(bus0.x_valid), XW'(1));
        chk("basic_e0", XW'(bus0.x[15:0]),      XW'(16'h0001));
        chk("basic_e9", XW'(bus0.x[159:144]),   XW'(16'h000A));
        cycle(1'b0, '0, 1'b1);
        chk("basic_win_cnt", XW'(wc0), XW'(16'd1));

        // Conversion table, window held with x_ready low.
        do_reset(0);
        for (int i = 0; i < NE; i++) send(tab[i].din, 1'b0);
        for (int i = 0; i < NE; i++) begin
            chk($sformatf("conv_s0_e%0d", i), XW'(bus0.x[BW*i +: BW]), XW'(tab[i].e0));
            chk($sformatf("conv_s2_e%0d", i), XW'(bus2.x[BW*i +: BW]), XW'(tab[i].e2));
        end
        chk("conv_sat", XW'(sat0), XW'(1));

        // Backpressure: sample pending for 20 cycles while the window is unaccepted.
        for (int i = 0; i < 20; i++) cycle(1'b1, 16'h0BAD, 1'b0);
        send(16'h0BAD, 1'b1);
        for (int i = 0; i < NE - 1; i++) send(16'h0100 + 16'(i), 1'b1);
        cycle(1'b0, '0, 1'b0);
        chk("sat_sticky", XW'(sat0), XW'(1));

        // Asynchronous reset in the middle of a window.
        do_reset(0);
        for (int i = 0; i < 6; i++) send(16'h0020 + 16'(i), 1'b1);
        do_reset(2);
        for (int i = 0; i < NE - 1; i++) send(16'h0040 + 16'(i), 1'b1);
        chk("rst_refill_not_valid", XW'(bus0.x_valid), XW'(0));
        send(16'h0050, 1'b1);
        chk("rst_refill_valid", XW'(bus0.x_valid), XW'(1));
        cycle(1'b0, '0, 1'b1);

        // Samples 1..15 with x_ready high: two windows when overlapping, one otherwise.
        do_reset(0);
        for (int i = 1; i <= 15; i++) send(16'(i), 1'b1);
        cycle(1'b0, '0, 1'b1);
`ifdef ECG_WINDOW_LOADER_OVERLAP_EN
        chk("overlap_win_cnt", XW'(wc0), XW'(16'd2));
`else
        chk("overlap_win_cnt", XW'(wc0), XW'(16'd1));
`endif

        // Randomized traffic against the model.
        do_reset(0);
        pv = 1'b0;
        pd = '0;
        for (int c = 0; c < 3000; c++) begin
            if (!pv && $urandom_range(0, 3) != 0) begin
                pv = 1'b1;
                pd = rand_data();
            end
            xr  = ($urandom_range(0, 2) != 0);
            acc = pv && exp_sr();
            cycle(pv, pd, xr);
            if (acc) pv = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound.
    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ecg_window_loader.md
Name: ecg_window_loader

Overview:
- Upstream feeder for the arrhythmia classifier top.
- Accepts one raw two's-complement ECG sample per handshake and converts each to the 16-bit sign-magnitude fixed-point format used by the encoder layers (bit 15 = sign, bits 14:0 = magnitude).
- Assembles 10 samples into the packed vector that drives the classifier's x input, and holds it stable until the consumer accepts it.

Parameters:
- BITSIZE, 16, word width of samples and vector elements.
- NELEM, 10, elements per window; fixed to match the classifier input.
- SHIFT, 0, arithmetic right-shift applied to the magnitude (input scaling), range 0..BITSIZE-2.
- STRIDE, 5, new samples per window in overlap mode, range 1..NELEM; ignored unless OVERLAP_EN is defined.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-low reset.
- s_data  in  BITSIZE  raw sample, two's complement.
- s_valid  in  1  s_data is valid.
- s_ready  out  1  loader can accept a sample.
- x  out  BITSIZE*NELEM  window; element i is at x[BITSIZE*i +: BITSIZE]; element 0 is the oldest sample.
- x_valid  out  1  x holds a complete window.
- x_ready  in  1  consumer accepts x.
- sat_seen  out  1  sticky; a saturating conversion has occurred.
- win_cnt  out  16  count of windows accepted by the consumer; wraps 0xFFFF -> 0.

Behaviour:
- Reset (reset=0, asynchronous):
  - x = 0, x_valid = 0, sat_seen = 0, win_cnt = 0.
  - Fill counter = 0, state = FILL, so s_ready = 1 one cycle after reset deasserts.
  - Reset mid-window discards all partial data; no window is emitted.
- Conversion (combinational, applied to s_data at capture):
  - s_data >= 0: sign = 0, mag = s_data[14:0] >> SHIFT.
  - s_data < 0: mag = (-s_data) >> SHIFT, sign = 1.
  - s_data = 0x8000: mag saturates to 0x7FFF before the shift, and sat_seen sets.
  - If the resulting mag = 0, sign is forced to 0 (no negative zero).
- Capture:
  - A sample is taken on a clock edge where s_valid & s_ready.
  - x shifts down one element: element i <= element i+1; the converted sample enters element NELEM-1. Fill counter increments.
- State FILL:
  - s_ready = 1, x_valid = 0.
  - When a capture brings the counter to NELEM, go to FULL on that same edge. x_valid rises the next cycle (1-cycle latency from the 10th sample).
- State FULL:
  - s_ready = 0, x_valid = 1, and x is held bit-stable.
  - On x_ready = 1: go to FILL, counter = 0, win_cnt increments.
  - x keeps its old contents until the next capture overwrites it; x_valid is already 0 in the cycle after the accept.
- No simultaneous capture and emit: s_ready is low for the whole of FULL. Minimum throughput is NELEM+1 cycles per window.
- s_valid while s_ready = 0: the sample is not taken. The producer must hold it (standard valid/ready).
- x_ready while x_valid = 0: ignored.
- win_cnt wrap-around is silent. sat_seen clears only on reset.

Optional Feature:
- Macro: ECG_WINDOW_LOADER_OVERLAP_EN.
- Defined:
  - Sliding window. On the accept in FULL, the counter is set to NELEM-STRIDE instead of 0, and x is retained.
  - The next window is emitted after STRIDE new captures, with the oldest STRIDE elements shifted out.
  - The first window after reset still needs NELEM samples.
  - STRIDE = NELEM behaves identically to the macro being undefined.
- Undefined: non-overlapping blocks of NELEM samples; STRIDE has no effect.

Test Plan:
- Basic fill: reset, feed 1..10 back-to-back with x_ready = 1 -> x_valid rises 1 cycle after the 10th capture; element 0 = 0x0001, element 9 = 0x000A; win_cnt = 1 after the accept.
- Negative conversion and saturation: feed -3, 0x8000, 0, then 7 more zeros -> element 0 = 0x8003, element 1 = 0xFFFF, element 2 = 0x0000; sat_seen = 1 and stays 1.
- Backpressure: complete a window with x_ready = 0 for 20 cycles and s_valid held 1 -> s_ready = 0 and x unchanged throughout; no sample is lost; the next window begins after x_ready pulses.
- Scaling, SHIFT = 2: feed -1 and 0x0010 -> 0x0000 (negative zero suppressed) and 0x0004.
- Async reset mid-window: assert reset after 6 samples -> x = 0, x_valid = 0 immediately; 10 further samples are needed for the next x_valid.
- Overlap with the macro defined and STRIDE = 5: feed 1..15 with x_ready = 1 -> first window 1..10, second window 6..15; x_valid pulses twice; win_cnt = 2.
